id_stage: RTL and testbench

Instruction decode and issue stage that sits directly upstream of the execute ALU. It accepts one fetched instruction per handshake and decodes the RV32I integer ALU subset into ALU opcode, operand-select flags and immediate. It reads source operands from the register file, then presents stable operands before raising a one-cycle rising-edge strobe `ex_en`, on which the ALU latches its result. An optional register scoreboard stalls issue on read-after-write hazards until writeback completes.

---
 rtl/id_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_id_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: decode/issue stage in front of the execute ALU.
// Captures one RV32I ALU-subset instruction, reads its operands from a
// combinational register file and issues it with a one-cycle ex_en strobe.
// Optional feature: define ID_HAZARD_EN to add a 32-bit register scoreboard
// that holds issue in READ on read-after-write hazards until writeback.
module id_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_valid,
   input  logic [31:0] if_inst,
   input  logic [31:0] if_pc,
   output logic        id_ready,
   output logic [4:0]  rf_raddr1,
   output logic [4:0]  rf_raddr2,
   input  logic [31:0] rf_rdata1,
   input  logic [31:0] rf_rdata2,
   input  logic        wb_done,
   input  logic [4:0]  wb_rd,
   output logic        ex_en,
   output logic        pc_en,
   output logic        imm_en,
   output logic [31:0] pc,
   output logic [31:0] reg_1,
   output logic [31:0] reg_2,
   output logic [31:0] imm,
   output logic [2:0]  aluop,
   output logic [4:0]  rd,
   output logic        rd_we,
   output logic        illegal
);

   localparam logic [2:0] ALU_OR  = 3'd0;
   localparam logic [2:0] ALU_AND = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_ADD = 3'd3;
   localparam logic [2:0] ALU_SUB = 3'd4;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_SETUP, S_FIRE} state_t;

   state_t      state, state_nx;
   logic [31:0] inst_q, pc_q;
   logic        load;

   logic        dec_legal, dec_pc_en, dec_imm_en, dec_lui;
   logic        use_rs1, use_rs2;
   logic [2:0]  dec_op;
   logic [31:0] dec_imm;
   logic        hazard;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   assign opc = inst_q[6:0];
   assign f3  = inst_q[14:12];
   assign f7  = inst_q[31:25];

   // Decode the captured instruction into ALU controls and immediate
   always_comb begin
      dec_legal  = 1'b0;
      dec_op     = ALU_ADD;
      dec_pc_en  = 1'b0;
      dec_imm_en = 1'b0;
      dec_imm    = 32'h0;
      dec_lui    = 1'b0;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      case (opc)
         OPC_OP: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            if (f7 == 7'b0000000) begin
               dec_legal = 1'b1;
               case (f3)
                  3'b000:  dec_op = ALU_ADD;
                  3'b100:  dec_op = ALU_XOR;
                  3'b110:  dec_op = ALU_OR;
                  3'b111:  dec_op = ALU_AND;
                  default: dec_legal = 1'b0;
               endcase
            end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
               dec_legal = 1'b1;
               dec_op    = ALU_SUB;
            end
         end
         OPC_OPIMM: begin
            use_rs1    = 1'b1;
            dec_imm_en = 1'b1;
            dec_imm    = {{20{inst_q[31]}}, inst_q[31:20]};
            dec_legal  = 1'b1;
            case (f3)
               3'b000:  dec_op = ALU_ADD;
               3'b100:  dec_op = ALU_XOR;
               3'b110:  dec_op = ALU_OR;
               3'b111:  dec_op = ALU_AND;
               default: dec_legal = 1'b0;
            endcase
         end
         OPC_LUI: begin
            dec_legal  = 1'b1;
            dec_lui    = 1'b1;
            dec_imm_en = 1'b1;
            dec_imm    = {inst_q[31:12], 12'h000};
         end
         OPC_AUIPC: begin
            dec_legal  = 1'b1;
            dec_pc_en  = 1'b1;
            dec_imm_en = 1'b1;
            dec_imm    = {inst_q[31:12], 12'h000};
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Register-file addresses are only presented while reading
   always_comb begin
      rf_raddr1 = 5'd0;
      rf_raddr2 = 5'd0;
      if (state == S_READ) begin
         rf_raddr1 = dec_lui ? 5'd0 : inst_q[19:15];
         rf_raddr2 = inst_q[24:20];
      end
   end

`ifdef ID_HAZARD_EN
   logic [31:0] sb;

   // Scoreboard: clear on writeback, set on issue; set wins on a collision
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb <= 32'h0;
      end else begin
         if (wb_done && wb_rd != 5'd0) sb[wb_rd] <= 1'b0;
         if (state == S_FIRE && rd_we) sb[rd] <= 1'b1;
      end
   end

   assign hazard = (use_rs1 && sb[inst_q[19:15]]) || (use_rs2 && sb[inst_q[24:20]]);
`else
   // Without the scoreboard, software schedules around hazards
   logic wb_unused;
   assign wb_unused = ^{wb_done, wb_rd, use_rs1, use_rs2};
   assign hazard    = 1'b0;
`endif

   // Next-state logic, reject pulse and operand-load enable
   always_comb begin
      state_nx = state;
      illegal  = 1'b0;
      load     = 1'b0;
      case (state)
         S_IDLE:  if (id_ready && if_valid) state_nx = S_READ;
         S_READ: begin
            if (!dec_legal) begin
               illegal  = 1'b1;
               state_nx = S_IDLE;
            end else if (!hazard) begin
               load     = 1'b1;
               state_nx = S_SETUP;
            end
         end
         S_SETUP: state_nx = S_FIRE;
         S_FIRE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State plus registered handshake/strobe so ex_en is a clean flop output
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         id_ready <= 1'b0;
         ex_en    <= 1'b0;
      end else begin
         state    <= state_nx;
         id_ready <= (state_nx == S_IDLE);
         ex_en    <= (state_nx == S_FIRE);
      end
   end

   // Capture the fetched instruction on the accept handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_q <= 32'h0;
         pc_q   <= 32'h0;
      end else if (state == S_IDLE && id_ready && if_valid) begin
         inst_q <= if_inst;
         pc_q   <= if_pc;
      end
   end

   // Operand outputs load once in READ and then hold until the next load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc     <= 32'h0;
         reg_1  <= 32'h0;
         reg_2  <= 32'h0;
         imm    <= 32'h0;
         aluop  <= 3'd0;
         pc_en  <= 1'b0;
         imm_en <= 1'b0;
         rd     <= 5'd0;
         rd_we  <= 1'b0;
      end else if (load) begin
         pc     <= pc_q;
         reg_1  <= dec_lui ? 32'h0 : rf_rdata1;
         reg_2  <= rf_rdata2;
         imm    <= dec_imm;
         aluop  <= dec_op;
         pc_en  <= dec_pc_en;
         imm_en <= dec_imm_en;
         rd     <= inst_q[11:7];
         rd_we  <= (inst_q[11:7] != 5'd0);
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed cases plus randomized instructions checked
// against a decode model built from the instruction-set rules.
module tb_id_stage;

   logic        clk, rst, if_valid, id_ready, wb_done;
   logic [31:0] if_inst, if_pc, rf_rdata1, rf_rdata2;
   logic [4:0]  rf_raddr1, rf_raddr2, wb_rd, rd;
   logic        ex_en, pc_en, imm_en, rd_we, illegal;
   logic [31:0] pc, reg_1, reg_2, imm;
   logic [2:0]  aluop;

   int checks = 0;
   int failures = 0;

   logic [31:0] regs [32];

   typedef struct {
      logic        legal;
      logic [2:0]  aluop;
      logic        pc_en, imm_en, rd_we;
      logic [31:0] imm, r1, r2, pcv;
      logic [4:0]  rd, ra1, ra2;
   } exp_t;

   exp_t prev;

   id_stage dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
      .id_ready(id_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_done(wb_done), .wb_rd(wb_rd),
      .ex_en(ex_en), .pc_en(pc_en), .imm_en(imm_en), .pc(pc), .reg_1(reg_1),
      .reg_2(reg_2), .imm(imm), .aluop(aluop), .rd(rd), .rd_we(rd_we), .illegal(illegal)
   );

   assign rf_rdata1 = regs[rf_raddr1];
   assign rf_rdata2 = regs[rf_raddr2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // ALU op for the four shared f3 encodings; -1 means not in the subset
   function automatic int alu_of_f3(input logic [2:0] f);
      case (f)
         3'd0: return 3;
         3'd4: return 2;
         3'd6: return 0;
         3'd7: return 1;
         default: return -1;
      endcase
   endfunction

   function automatic exp_t model(input logic [31:0] inst, input logic [31:0] ipc);
      exp_t e;
      int   code;
      logic [4:0] rs1, rs2;
      rs1 = inst[19:15];
      rs2 = inst[24:20];
      code = alu_of_f3(inst[14:12]);
      e.legal = 0; e.aluop = 0; e.pc_en = 0; e.imm_en = 0; e.imm = 0;
      e.r1 = regs[rs1]; e.r2 = regs[rs2]; e.pcv = ipc; e.ra1 = rs1; e.ra2 = rs2;
      case (inst[6:0])
         7'b0110011: begin
            if (inst[31:25] == 7'h00 && code >= 0) begin e.legal = 1; e.aluop = 3'(code); end
            else if (inst[31:25] == 7'h20 && inst[14:12] == 3'd0) begin e.legal = 1; e.aluop = 4; end
         end
         7'b0010011: begin
            if (code >= 0) begin
               e.legal = 1; e.aluop = 3'(code); e.imm_en = 1;
               e.imm = 32'($signed(inst[31:20]));
            end
         end
         7'b0110111: begin
            e.legal = 1; e.aluop = 3; e.imm_en = 1; e.imm = inst & 32'hFFFF_F000;
            e.r1 = 0; e.ra1 = 0;
         end
         7'b0010111: begin
            e.legal = 1; e.aluop = 3; e.pc_en = 1; e.imm_en = 1; e.imm = inst & 32'hFFFF_F000;
         end
         default: e.legal = 0;
      endcase
      e.rd = inst[11:7];
      e.rd_we = e.legal && (inst[11:7] != 0);
      return e;
   endfunction

   task automatic check_ops(input string tag, input exp_t e);
      check({tag, "_pc"}, pc, e.pcv);
      check({tag, "_reg1"}, reg_1, e.r1);
      check({tag, "_reg2"}, reg_2, e.r2);
      check({tag, "_imm"}, imm, e.imm);
      check({tag, "_aluop"}, 32'(aluop), 32'(e.aluop));
      check({tag, "_pc_en"}, 32'(pc_en), 32'(e.pc_en));
      check({tag, "_imm_en"}, 32'(imm_en), 32'(e.imm_en));
      check({tag, "_rd"}, 32'(rd), 32'(e.rd));
      check({tag, "_rd_we"}, 32'(rd_we), 32'(e.rd_we));
   endtask

   task automatic check_zero(input string tag);
      exp_t z;
      z.legal = 0; z.aluop = 0; z.pc_en = 0; z.imm_en = 0; z.rd_we = 0;
      z.imm = 0; z.r1 = 0; z.r2 = 0; z.pcv = 0; z.rd = 0; z.ra1 = 0; z.ra2 = 0;
      check_ops(tag, z);
      check({tag, "_ex_en"}, 32'(ex_en), 0);
      check({tag, "_illegal"}, 32'(illegal), 0);
      prev = z;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!id_ready && n < 20) begin @(negedge clk); n++; end
      check({tag, "_ready"}, 32'(id_ready), 1);
   endtask

   task automatic writeback(input logic [4:0] r);
      wb_done = 1'b1; wb_rd = r;
      @(negedge clk);
      wb_done = 1'b0; wb_rd = 5'd0;
   endtask

   // Issue one instruction and check every cycle of its trip through the stage
   task automatic run_inst(input string tag, input logic [31:0] inst, input logic [31:0] ipc, input bit do_wb);
      exp_t e;
      wait_ready(tag);
      e = model(inst, ipc);
      if_valid = 1'b1; if_inst = inst; if_pc = ipc;
      @(negedge clk);
      if_valid = 1'b0;
      check({tag, "_illegal"}, 32'(illegal), 32'(!e.legal));
      check({tag, "_raddr1"}, 32'(rf_raddr1), 32'(e.ra1));
      check({tag, "_raddr2"}, 32'(rf_raddr2), 32'(e.ra2));
      check({tag, "_ex_read"}, 32'(ex_en), 0);
      @(negedge clk);
      if (!e.legal) begin
         check({tag, "_ready_after_ill"}, 32'(id_ready), 1);
         check({tag, "_illegal_once"}, 32'(illegal), 0);
         check({tag, "_ex_ill"}, 32'(ex_en), 0);
         check_ops({tag, "_hold"}, prev);
         return;
      end
      check({tag, "_ex_setup"}, 32'(ex_en), 0);
      check_ops({tag, "_setup"}, e);
      @(negedge clk);
      check({tag, "_ex_fire"}, 32'(ex_en), 1);
      check_ops({tag, "_fire"}, e);
      @(negedge clk);
      check({tag, "_ex_fall"}, 32'(ex_en), 0);
      check({tag, "_ready_back"}, 32'(id_ready), 1);
      prev = e;
      if (do_wb && e.rd_we) writeback(e.rd);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [2:0] f3s [4];
      logic [31:0] r;
      int k;
      f3s[0] = 3'd0; f3s[1] = 3'd4; f3s[2] = 3'd6; f3s[3] = 3'd7;
      r = $urandom;
      k = $urandom_range(0, 6);
      case (k)
         0, 1: r = {7'h00, r[24:15], f3s[$urandom_range(0, 3)], r[11:7], 7'b0110011};
         2:    r = {7'h20, r[24:15], 3'd0, r[11:7], 7'b0110011};
         3:    r = {r[31:7], 7'b0010011};
         4:    r = {r[31:7], 7'b0110111};
         5:    r = {r[31:7], 7'b0010111};
         default: r = r;
      endcase
      return r;
   endfunction

   initial begin
      logic [31:0] t;
      rst = 1'b0; if_valid = 1'b0; if_inst = 0; if_pc = 0; wb_done = 1'b0; wb_rd = 0;
      for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom;
      repeat (2) @(negedge clk);
      check_zero("rst_hold");
      check("rst_ready_low", 32'(id_ready), 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_release_ready", 32'(id_ready), 1);

      // addi x1,x0,5
      run_inst("addi", 32'h0050_0093, 32'h100, 1'b1);
      check("addi_aluop_k", 32'(aluop), 3);
      check("addi_imm_k", imm, 5);
      check("addi_reg1_k", reg_1, 0);
      check("addi_rd_k", 32'(rd), 1);

      // sub x3,x1,x2 with x1=9, x2=4
      regs[1] = 9; regs[2] = 4;
      run_inst("sub", 32'h4020_81B3, 32'h104, 1'b1);
      check("sub_aluop_k", 32'(aluop), 4);
      check("sub_reg1_k", reg_1, 9);
      check("sub_reg2_k", reg_2, 4);
      check("sub_imm_en_k", 32'(imm_en), 0);

      // auipc x5,0x12345 at 0x200
      run_inst("auipc", 32'h1234_5297, 32'h200, 1'b1);
      check("auipc_imm_k", imm, 32'h1234_5000);
      check("auipc_pc_k", pc, 32'h200);
      check("auipc_pc_en_k", 32'(pc_en), 1);

      // lui x7 with negative immediate, nonzero rs1 field ignored
      run_inst("lui", 32'hFFFF_F3B7, 32'h204, 1'b1);
      // load opcode is rejected
      run_inst("load", 32'h0000_A083, 32'h208, 1'b1);
      // rd=x0 must not request writeback
      run_inst("rd0", 32'h0010_0013, 32'h20C, 1'b1);

`ifdef ID_HAZARD_EN
      // addi x1 then add x2,x1,x1 stalls until x1 is written back
      run_inst("hz_addi", 32'h0050_0093, 32'h300, 1'b0);
      wait_ready("hz_add");
      if_valid = 1'b1; if_inst = 32'h0010_8133; if_pc = 32'h304;
      @(negedge clk);
      if_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("hz_stall_ex", 32'(ex_en), 0);
         check("hz_stall_ready", 32'(id_ready), 0);
         @(negedge clk);
      end
      writeback(5'd0);
      check("hz_wb0_ignored", 32'(ex_en), 0);
      @(negedge clk);
      check("hz_still_stalled", 32'(ex_en), 0);
      writeback(5'd1);
      check("hz_release_read", 32'(ex_en), 0);
      @(negedge clk);
      check("hz_release_setup", 32'(ex_en), 0);
      @(negedge clk);
      check("hz_release_fire", 32'(ex_en), 1);
      check("hz_reg1", reg_1, regs[1]);
      check("hz_rd", 32'(rd), 2);
      @(negedge clk);
      prev = model(32'h0010_8133, 32'h304);
      writeback(5'd2);
`endif

      // randomized instruction stream
      for (int n = 0; n < 60; n++) begin
         for (int i = 1; i < 32; i++) if ($urandom_range(0, 3) == 0) regs[i] = $urandom;
         t = rand_inst();
         run_inst("rand", t, {$urandom} & 32'hFFFF_FFFC, 1'b1);
      end

      // reset pulled low during SETUP drops the instruction
      wait_ready("rst_mid");
      if_valid = 1'b1; if_inst = 32'h0050_0093; if_pc = 32'h400;
      @(negedge clk);
      if_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_zero("rst_mid");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_ready", 32'(id_ready), 1);
      check("rst_mid_ex", 32'(ex_en), 0);
      @(negedge clk);
      check("rst_mid_ex2", 32'(ex_en), 0);
      run_inst("post_rst", 32'h00A0_0113, 32'h500, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
